// File: rtl/qft_twiddle_gen_pkg.sv
// Shared QFT datapath constants: twiddle width, Q2.10 scaling, sequencer states and the
// (cos, sin) ROM for rotation orders k = 2..8.
package qft_pkg;

    localparam int TW_W     = 12;
    localparam int FRAC_W   = 10;
    localparam int ONE_Q210 = 1 << FRAC_W;
    localparam int IDX_W    = 3;
    localparam int K_W      = 4;
    localparam int NQ_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    typedef struct packed {
        logic signed [TW_W-1:0] cos_v;
        logic signed [TW_W-1:0] sin_v;
    } twiddle_t;

    // Entry i holds k = i + 2, rounded to nearest; the last slot pads the table to a power of two.
    localparam twiddle_t TW_ROM [8] = '{
        '{12'sd0,                12'(ONE_Q210)},
        '{12'sd724,              12'sd724},
        '{12'sd946,              12'sd392},
        '{12'sd1004,             12'sd200},
        '{12'sd1019,             12'sd100},
        '{12'sd1023,             12'sd50},
        '{12'(ONE_Q210),         12'sd25},
        '{12'sd0,                12'sd0}
    };

endpackage

// File: rtl/qft_twiddle_gen_if.sv
// Twiddle valid/ready channel between the QFT sequencer (master) and the complex multiplier (slave).
interface qft_twiddle_gen_if;
    import qft_pkg::*;

    logic                   tw_valid;
    logic                   tw_ready;
    logic [IDX_W-1:0]       tgt_idx;
    logic [IDX_W-1:0]       ctl_idx;
    logic [K_W-1:0]         k_out;
    logic signed [TW_W-1:0] cos_2p_by;
    logic signed [TW_W-1:0] sin_2p_by;

    modport master (
        output tw_valid, tgt_idx, ctl_idx, k_out, cos_2p_by, sin_2p_by,
        input  tw_ready
    );

    modport slave (
        input  tw_valid, tgt_idx, ctl_idx, k_out, cos_2p_by, sin_2p_by,
        output tw_ready
    );

endinterface

// File: rtl/qft_twiddle_gen_rom.sv
// Combinational k -> (cos, sin) lookup. With QFT_INVERSE_EN defined the sine is negated
// so the multiplier applies e^{-i2pi/2^k} for the inverse QFT.
module qft_twiddle_rom
    import qft_pkg::*;
(
    input  logic [K_W-1:0]         k,
    output logic signed [TW_W-1:0] cos_v,
    output logic signed [TW_W-1:0] sin_v
);

    twiddle_t   entry;
    logic [2:0] idx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        entry = '0;
        idx   = 3'(k - 4'd2);
        if (k >= 4'd2 && k <= 4'd8) begin
            entry = TW_ROM[idx];
        end
    end

    assign cos_v = entry.cos_v;
`ifdef QFT_INVERSE_EN
    assign sin_v = -entry.sin_v;
`else
    assign sin_v = entry.sin_v;
`endif

endmodule

// File: rtl/qft_twiddle_gen.sv
// QFT twiddle sequencer: walks every controlled-phase R_k (j outer, c inner) and presents
// registered indices and twiddles on a valid/ready channel. Sine sign set by QFT_INVERSE_EN.
module qft_twiddle_gen
    import qft_pkg::*;
#(
    parameter int MAX_QUBITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NQ_W-1:0]   nq,
    qft_twiddle_gen_if.master tw,
    output logic              busy,
    output logic              done
);

    state_t                 state, state_nxt;
    logic [NQ_W-1:0]        nq_q;
    logic [IDX_W-1:0]       j_q, c_q, j_nxt, c_nxt;
    logic [K_W-1:0]         k_nxt;
    logic                   load;
    logic                   nq_ok, row_end, last_beat;
    logic signed [TW_W-1:0] rom_cos, rom_sin;

    logic [IDX_W-1:0]       tgt_q, ctl_q;
    logic [K_W-1:0]         k_q;
    logic signed [TW_W-1:0] cos_q, sin_q;

    assign nq_ok     = (nq >= 4'd2) && (nq <= 4'(MAX_QUBITS));
    assign row_end   = ({1'b0, c_q} == nq_q - 4'd1);
    assign last_beat = row_end && ({1'b0, j_q} == nq_q - 4'd2);

    always_comb begin
        state_nxt = state;
        j_nxt     = j_q;
        c_nxt     = c_q;
        load      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (nq_ok) begin
                        state_nxt = S_RUN;
                        j_nxt     = '0;
                        c_nxt     = 3'd1;
                        load      = 1'b1;
                    end else begin
                        state_nxt = S_FIN;
                    end
                end
            end
            S_RUN: begin
                if (tw.tw_ready) begin
                    if (last_beat) begin
                        state_nxt = S_FIN;
                    end else if (row_end) begin
                        j_nxt = j_q + 3'd1;
                        c_nxt = j_q + 3'd2;
                        load  = 1'b1;
                    end else begin
                        c_nxt = c_q + 3'd1;
                        load  = 1'b1;
                    end
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        k_nxt = K_W'(c_nxt) - K_W'(j_nxt) + 4'd1;
    end

    qft_twiddle_rom u_rom (
        .k     (k_nxt),
        .cos_v (rom_cos),
        .sin_v (rom_sin)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            nq_q  <= '0;
            j_q   <= '0;
            c_q   <= '0;
            tgt_q <= '0;
            ctl_q <= '0;
            k_q   <= '0;
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            state <= state_nxt;
            j_q   <= j_nxt;
            c_q   <= c_nxt;
            if (state == S_IDLE && start) begin
                nq_q <= nq;
            end
            // Fields only move on a handshake (or the first load); they read zero outside RUN.
            if (load) begin
                tgt_q <= j_nxt;
                ctl_q <= c_nxt;
                k_q   <= k_nxt;
                cos_q <= rom_cos;
                sin_q <= rom_sin;
            end else if (state_nxt != S_RUN) begin
                tgt_q <= '0;
                ctl_q <= '0;
                k_q   <= '0;
                cos_q <= '0;
                sin_q <= '0;
            end
        end
    end

    assign tw.tw_valid  = (state == S_RUN);
    assign tw.tgt_idx   = tgt_q;
    assign tw.ctl_idx   = ctl_q;
    assign tw.k_out     = k_q;
    assign tw.cos_2p_by = cos_q;
    assign tw.sin_2p_by = sin_q;
    assign busy         = (state == S_RUN);
    assign done         = (state == S_FIN);

endmodule

// File: tb/tb_qft_twiddle_gen.sv
// Randomized bench for qft_twiddle_gen: expected beats come from nested loops over (j, c)
// and twiddles from real-valued cos/sin rounded to Q2.10.
module tb_qft_twiddle_gen;
    import qft_pkg::*;

    typedef struct {
        int j;
        int c;
        int k;
        int cs;
        int sn;
    } beat_t;

    localparam real PI = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NQ_W-1:0] nq;
    logic            busy;
    logic            done;

    int vectors     = 0;
    int miscompares = 0;

    qft_twiddle_gen_if tw ();

    qft_twiddle_gen #(.MAX_QUBITS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .nq    (nq),
        .tw    (tw),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int q210(input real x);
        return $rtoi(x * real'(ONE_Q210) + 0.5);
    endfunction

    function automatic beat_t make_beat(input int j, input int c);
        beat_t b;
        real   ang;
        b.j  = j;
        b.c  = c;
        b.k  = c - j + 1;
        ang  = 2.0 * PI / (2.0 ** b.k);
        b.cs = q210($cos(ang));
        b.sn = q210($sin(ang));
`ifdef QFT_INVERSE_EN
        b.sn = -b.sn;
`endif
        return b;
    endfunction

    // mode 0: ready always high, 1: random ready, 2: repeating 1,0,0,1 pattern.
    task automatic run_seq(input int n, input int mode, input int abort_at);
        beat_t exp_q[$];
        int    idx     = 0;
        int    last_hs = -1;
        int    pat     = 0;
        bit    seen    = 1'b0;
        bit    legal;
        logic  r;

        legal = (n >= 2) && (n <= 8);
        if (legal) begin
            for (int j = 0; j <= n - 2; j++) begin
                for (int c = j + 1; c <= n - 1; c++) begin
                    exp_q.push_back(make_beat(j, c));
                end
            end
        end

        @(negedge clk);
        check("idle_valid", int'(tw.tw_valid), 0);
        start       = 1'b1;
        nq          = 4'(n);
        tw.tw_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (done) begin
                check("done_busy", int'(busy), 0);
                check("done_valid", int'(tw.tw_valid), 0);
                check("beat_count", idx, exp_q.size());
                check("done_latency", cyc, legal ? last_hs + 1 : 1);
                seen  = 1'b1;
                start = 1'b0;
                break;
            end else if (tw.tw_valid) begin
                if (idx >= exp_q.size()) begin
                    check("extra_beat", idx, exp_q.size());
                    break;
                end
                check("tgt_idx", int'(tw.tgt_idx), exp_q[idx].j);
                check("ctl_idx", int'(tw.ctl_idx), exp_q[idx].c);
                check("k_out", int'(tw.k_out), exp_q[idx].k);
                check("cos_2p_by", int'(tw.cos_2p_by), exp_q[idx].cs);
                check("sin_2p_by", int'(tw.sin_2p_by), exp_q[idx].sn);
                check("run_busy", int'(busy), 1);
                if (idx == abort_at) begin
                    rst   = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    check("abort_valid", int'(tw.tw_valid), 0);
                    check("abort_busy", int'(busy), 0);
                    check("abort_done", int'(done), 0);
                    check("abort_tgt", int'(tw.tgt_idx), 0);
                    check("abort_sin", int'(tw.sin_2p_by), 0);
                    rst = 1'b0;
                    return;
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (pat % 4 == 0) || (pat % 4 == 3);
                endcase
                pat++;
                tw.tw_ready = r;
                if (r) begin
                    idx++;
                    last_hs = cyc;
                end
                // start while busy must be ignored, whatever nq says.
                start = ($urandom_range(0, 3) == 0);
                nq    = 4'($urandom_range(0, 15));
            end else begin
                check("valid_or_done", int'(tw.tw_valid), 1);
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", int'(seen), 1);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("post_valid", int'(tw.tw_valid), 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        nq          = '0;
        tw.tw_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(tw.tw_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_k", int'(tw.k_out), 0);
        check("rst_cos", int'(tw.cos_2p_by), 0);
        rst = 1'b0;

        run_seq(3, 0, -1);
        run_seq(8, 0, -1);
        run_seq(4, 2, -1);
        run_seq(1, 0, -1);
        run_seq(9, 0, -1);
        run_seq(5, 0, 3);
        run_seq(5, 1, -1);
        for (int i = 0; i < 10; i++) begin
            run_seq(int'($urandom_range(0, 10)), int'($urandom_range(0, 2)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
